// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, input synchronizer with rising-edge
// interrupts, and a drain/apply/restore sequencer that reprograms pad drive
// modes without glitching actively driven pins.
module gpio_pad_ctrl #(
  parameter int NPINS  = 8,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_valid,
  output logic                 reg_ready,
  input  logic                 reg_write,
  input  logic [2:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic [NPINS-1:0]     pad_out,
  output logic [NPINS-1:0]     pad_oe_n,
  output logic [3*NPINS-1:0]   pad_dm,
  output logic [NPINS-1:0]     pad_inp_dis,
  input  logic [NPINS-1:0]     pad_in,
  output logic                 irq
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY, S_RESTORE} state_t;

  localparam logic [2:0]  A_DATA_OUT = 3'd0;
  localparam logic [2:0]  A_OUT_EN   = 3'd1;
  localparam logic [2:0]  A_DATA_IN  = 3'd2;
  localparam logic [2:0]  A_IRQ_EN   = 3'd3;
  localparam logic [2:0]  A_IRQ_STAT = 3'd4;
  localparam logic [2:0]  A_MODE     = 3'd5;
  localparam logic [15:0] CNT_LOAD   = 16'(SETTLE - 1);

  // Reset drive mode for every pin is 3'b001.
  function automatic logic [3*NPINS-1:0] dm_reset();
    logic [3*NPINS-1:0] r;
    for (int i = 0; i < NPINS; i++) r[3*i +: 3] = 3'b001;
    return r;
  endfunction

  // Input buffer is disabled exactly on pins whose drive mode is 3'b000.
  function automatic logic [NPINS-1:0] inp_dis_of(input logic [3*NPINS-1:0] dm);
    logic [NPINS-1:0] r;
    for (int i = 0; i < NPINS; i++) r[i] = (dm[3*i +: 3] == 3'b000);
    return r;
  endfunction

  function automatic logic [31:0] zext(input logic [NPINS-1:0] v);
    return {{(32-NPINS){1'b0}}, v};
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NPINS-1:0]     data_out_q, data_out_d;
  logic [NPINS-1:0]     out_en_q, out_en_d;
  logic [NPINS-1:0]     irq_en_q, irq_en_d;
  logic [NPINS-1:0]     irq_stat_q, irq_stat_d;
  logic [NPINS-1:0]     sync1_q, sync1_d;
  logic [NPINS-1:0]     sync2_q, sync2_d;
  logic [NPINS-1:0]     prev_q, prev_d;
  logic [NPINS-1:0]     force_q, force_d;
  logic [NPINS-1:0]     mask_q, mask_d;
  logic [2:0]           mdm_q, mdm_d;
  logic [3*NPINS-1:0]   dm_q, dm_d;
  logic [NPINS-1:0]     oe_n_q, oe_n_d;
  logic [NPINS-1:0]     inp_dis_q, inp_dis_d;
  logic                 irq_q, irq_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 accept;
  logic [NPINS-1:0]     w1c;
  logic [NPINS-1:0]     rise;
  logic                 unused_wdata;

  assign unused_wdata = ^reg_wdata[31:NPINS+3];

  assign reg_ready = (state_q == S_IDLE) && !rst;
  assign accept    = reg_valid && reg_ready;
  assign rise      = sync2_q & ~prev_q;
  assign w1c       = (accept && reg_write && reg_addr == A_IRQ_STAT) ?
                     reg_wdata[NPINS-1:0] : '0;

  assign pad_out     = data_out_q;
  assign pad_oe_n    = oe_n_q;
  assign pad_dm      = dm_q;
  assign pad_inp_dis = inp_dis_q;
  assign irq         = irq_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  // Next-state for register file, synchronizer, interrupts and the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_en_d    = out_en_q;
    irq_en_d    = irq_en_q;
    force_d     = force_q;
    mask_d      = mask_q;
    mdm_d       = mdm_q;
    dm_d        = dm_q;
    rsp_valid_d = accept;
    rsp_rdata_d = '0;
    sync1_d     = pad_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;

    // A new edge wins over a simultaneous write-1-to-clear.
    irq_stat_d  = (irq_stat_q & ~w1c) | (rise & irq_en_q);

    if (accept && !reg_write) begin
      case (reg_addr)
        A_DATA_OUT: rsp_rdata_d = zext(data_out_q);
        A_OUT_EN:   rsp_rdata_d = zext(out_en_q);
        A_DATA_IN:  rsp_rdata_d = zext(sync2_q);
        A_IRQ_EN:   rsp_rdata_d = zext(irq_en_q);
        A_IRQ_STAT: rsp_rdata_d = zext(irq_stat_q);
        A_MODE:     rsp_rdata_d = {31'd0, state_q != S_IDLE};
        default:    rsp_rdata_d = '0;
      endcase
    end

    if (accept && reg_write) begin
      case (reg_addr)
        A_DATA_OUT: data_out_d = reg_wdata[NPINS-1:0];
        A_OUT_EN:   out_en_d   = reg_wdata[NPINS-1:0];
        A_IRQ_EN:   irq_en_d   = reg_wdata[NPINS-1:0];
        A_MODE: begin
          mdm_d   = reg_wdata[2:0];
          mask_d  = reg_wdata[NPINS+2:3];
          force_d = reg_wdata[NPINS+2:3];
          cnt_d   = CNT_LOAD;
          state_d = S_DRAIN;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_DRAIN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_APPLY;
          for (int i = 0; i < NPINS; i++)
            if (mask_q[i]) dm_d[3*i +: 3] = mdm_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_APPLY: begin
        state_d = S_RESTORE;
        cnt_d   = CNT_LOAD;
      end
      S_RESTORE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
          force_d = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: ;
    endcase

    oe_n_d    = ~out_en_d | force_d;
    inp_dis_d = inp_dis_of(dm_d);
    irq_d     = |(irq_stat_q & irq_en_q);
  end

  // State register with synchronous reset of every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_en_q    <= '0;
      irq_en_q    <= '0;
      irq_stat_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      force_q     <= '0;
      mask_q      <= '0;
      mdm_q       <= '0;
      dm_q        <= dm_reset();
      oe_n_q      <= '1;
      inp_dis_q   <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_en_q    <= out_en_d;
      irq_en_q    <= irq_en_d;
      irq_stat_q  <= irq_stat_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      force_q     <= force_d;
      mask_q      <= mask_d;
      mdm_q       <= mdm_d;
      dm_q        <= dm_d;
      oe_n_q      <= oe_n_d;
      inp_dis_q   <= inp_dis_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl (NPINS=8, SETTLE=4).
module tb_gpio_pad_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_valid;
  logic        reg_ready;
  logic        reg_write;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  pad_out;
  logic [7:0]  pad_oe_n;
  logic [23:0] pad_dm;
  logic [7:0]  pad_inp_dis;
  logic [7:0]  pad_in;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_pad_ctrl #(.NPINS(8), .SETTLE(4)) dut (
    .clk(clk), .rst(rst),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_dm(pad_dm),
    .pad_inp_dis(pad_inp_dis), .pad_in(pad_in), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus transaction; returns response observed 1 time unit after accept edge.
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic rv, output logic [31:0] rd);
    int guard = 0;
    while (!reg_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!reg_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: reg_ready got %b want 1", reg_ready);
    end
    reg_valid = 1'b1; reg_write = w; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    rv = rsp_valid; rd = rsp_rdata;
    reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0;
    reg_wdata = '0; pad_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (reg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", reg_ready); end
    n_cmp++; if (pad_oe_n !== 8'hFF) begin n_bad++; $display("FAIL rst_oe_n: got %h want ff", pad_oe_n); end
    n_cmp++; if (pad_dm !== 24'o11111111) begin n_bad++; $display("FAIL rst_dm: got %o want 11111111", pad_dm); end
    n_cmp++; if (pad_out !== 8'h00) begin n_bad++; $display("FAIL rst_out: got %h want 00", pad_out); end
    n_cmp++; if (pad_inp_dis !== 8'h00) begin n_bad++; $display("FAIL rst_inp_dis: got %h want 00", pad_inp_dis); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (reg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", reg_ready); end
  endtask

  task automatic test_out_en();
    logic rv; logic [31:0] rd;
    bus(1'b1, 3'd1, 32'h0000_000F, rv, rd);
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL oe_rsp_valid: got %b want 1", rv); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oe_wr_rdata: got %h want 0", rd); end
    n_cmp++; if (pad_oe_n !== 8'hF0) begin n_bad++; $display("FAIL oe_n: got %h want f0", pad_oe_n); end
    bus(1'b1, 3'd0, 32'h0000_0005, rv, rd);
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL dout_rsp_valid: got %b want 1", rv); end
    n_cmp++; if (pad_out !== 8'h05) begin n_bad++; $display("FAIL pad_out: got %h want 05", pad_out); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
    bus(1'b1, 3'd0, 32'hFFFF_FF05, rv, rd);
    bus(1'b0, 3'd0, 32'h0, rv, rd);
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 1", rv); end
    n_cmp++; if (rd !== 32'h0000_0005) begin n_bad++; $display("FAIL rd_dout: got %h want 5", rd); end
    bus(1'b0, 3'd1, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0000_000F) begin n_bad++; $display("FAIL rd_oe: got %h want f", rd); end
  endtask

  task automatic test_addr_hole();
    logic rv; logic [31:0] rd;
    bus(1'b1, 3'd6, 32'hFFFF_FFFF, rv, rd);
    bus(1'b0, 3'd6, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rd_addr6: got %h want 0", rd); end
    bus(1'b0, 3'd7, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rd_addr7: got %h want 0", rd); end
    bus(1'b0, 3'd0, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0000_0005) begin n_bad++; $display("FAIL hole_no_alias: got %h want 5", rd); end
  endtask

  task automatic test_mode();
    logic rv; logic [31:0] rd;
    // dm=110 on pins 0-1
    bus(1'b1, 3'd5, 32'h0000_001E, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mode_wr_rdata: got %h want 0", rd); end
    for (int i = 1; i <= 9; i++) begin
      n_cmp++; if (reg_ready !== 1'b0) begin n_bad++; $display("FAIL mode_ready c%0d: got %b want 0", i, reg_ready); end
      n_cmp++; if (pad_oe_n !== 8'hF3) begin n_bad++; $display("FAIL mode_oe_n c%0d: got %h want f3", i, pad_oe_n); end
      n_cmp++;
      if (pad_dm !== ((i < 5) ? 24'o11111111 : 24'o11111166)) begin
        n_bad++; $display("FAIL mode_dm c%0d: got %o want %o", i, pad_dm, (i < 5) ? 24'o11111111 : 24'o11111166);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (reg_ready !== 1'b1) begin n_bad++; $display("FAIL mode_ready_end: got %b want 1", reg_ready); end
    n_cmp++; if (pad_oe_n !== 8'hF0) begin n_bad++; $display("FAIL mode_oe_n_end: got %h want f0", pad_oe_n); end
    bus(1'b0, 3'd5, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mode_busy_idle: got %h want 0", rd); end
    // mask 0: full sequence, no pad change
    bus(1'b1, 3'd5, 32'h0000_0002, rv, rd);
    for (int i = 1; i <= 9; i++) begin
      n_cmp++; if (reg_ready !== 1'b0) begin n_bad++; $display("FAIL mask0_ready c%0d: got %b want 0", i, reg_ready); end
      n_cmp++; if (pad_dm !== 24'o11111166) begin n_bad++; $display("FAIL mask0_dm c%0d: got %o want 11111166", i, pad_dm); end
      n_cmp++; if (pad_oe_n !== 8'hF0) begin n_bad++; $display("FAIL mask0_oe_n c%0d: got %h want f0", i, pad_oe_n); end
      @(posedge clk); #1;
    end
    n_cmp++; if (reg_ready !== 1'b1) begin n_bad++; $display("FAIL mask0_ready_end: got %b want 1", reg_ready); end
  endtask

  task automatic test_data_in();
    logic rv; logic [31:0] rd;
    pad_in = 8'hA4;
    repeat (3) @(posedge clk);
    #1;
    bus(1'b0, 3'd2, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0000_00A4) begin n_bad++; $display("FAIL data_in: got %h want a4", rd); end
    bus(1'b0, 3'd4, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL stat_no_en: got %h want 0", rd); end
    pad_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_irq();
    logic rv; logic [31:0] rd;
    bus(1'b1, 3'd3, 32'h0000_0001, rv, rd);
    pad_in = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus(1'b0, 3'd4, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL stat_set: got %h want 1", rd); end
    bus(1'b1, 3'd4, 32'h0000_0001, rv, rd);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_cleared: got %b want 0", irq); end
    bus(1'b0, 3'd4, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL stat_cleared: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic rv; logic [31:0] rd;
    pad_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    pad_in = 8'h01;
    @(posedge clk);
    @(posedge clk);
    #1;
    // W1C accepted on the same edge that the new rise is captured
    bus(1'b1, 3'd4, 32'h0000_0001, rv, rd);
    bus(1'b0, 3'd4, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL w1c_vs_edge: got %h want 1", rd); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL w1c_vs_edge_irq: got %b want 1", irq); end
  endtask

  task automatic test_mode_rst();
    logic rv; logic [31:0] rd;
    // dm=000 on pin 7
    bus(1'b1, 3'd5, 32'h0000_0400, rv, rd);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pad_inp_dis !== 8'h80) begin n_bad++; $display("FAIL apply_inp_dis: got %h want 80", pad_inp_dis); end
    n_cmp++; if (pad_dm !== 24'o01111166) begin n_bad++; $display("FAIL apply_dm: got %o want 01111166", pad_dm); end
    @(posedge clk); #1;
    n_cmp++; if (reg_ready !== 1'b0) begin n_bad++; $display("FAIL restore_ready: got %b want 0", reg_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (reg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", reg_ready); end
    @(posedge clk); #1;
    n_cmp++; if (pad_oe_n !== 8'hFF) begin n_bad++; $display("FAIL abort_oe_n: got %h want ff", pad_oe_n); end
    n_cmp++; if (pad_dm !== 24'o11111111) begin n_bad++; $display("FAIL abort_dm: got %o want 11111111", pad_dm); end
    n_cmp++; if (pad_inp_dis !== 8'h00) begin n_bad++; $display("FAIL abort_inp_dis: got %h want 00", pad_inp_dis); end
    n_cmp++; if (pad_out !== 8'h00) begin n_bad++; $display("FAIL abort_out: got %h want 00", pad_out); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL abort_irq: got %b want 0", irq); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rsp: got %b want 0", rsp_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (reg_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", reg_ready); end
    bus(1'b0, 3'd1, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_oe_reg: got %h want 0", rd); end
    bus(1'b0, 3'd5, 32'h0, rv, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_busy: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_out_en();
    test_addr_hole();
    test_mode();
    test_data_in();
    test_irq();
    test_back_to_back();
    test_mode_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameter NPINS, default 8, SHALL set the number of controlled pad pins (1..24).
REQ-002 Parameter SETTLE, default 4, SHALL set the cycles held in each reconfiguration wait state (>=1).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 reg_valid  in  1  register request valid.
REQ-007 reg_ready  out  1  register request accepted when reg_valid&reg_ready.
REQ-008 reg_write  in  1  1 = write, 0 = read.
REQ-009 reg_addr  in  3  register index.
REQ-010 reg_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-013 pad_out  out  NPINS  to pad OUT.
REQ-014 pad_oe_n  out  NPINS  to pad OE_N, active-low.
REQ-015 pad_dm  out  3*NPINS  to pad DM; pin i at bits [3i+2:3i].
REQ-016 pad_inp_dis  out  NPINS  to pad INP_DIS.
REQ-017 pad_in  in  NPINS  from pad IN, asynchronous.
REQ-018 irq  out  1  level interrupt.

Function
REQ-019 Register map SHALL be: 0 DATA_OUT rw; 1 OUT_EN rw; 2 DATA_IN ro; 3 IRQ_EN rw; 4 IRQ_STAT read/write-1-to-clear; 5 MODE (write: [2:0] dm, [NPINS+2:3] pin mask; read: bit0 busy); 6-7 read 0, writes ignored.
REQ-020 Only bits [NPINS-1:0] SHALL be stored; unused read bits SHALL be 0.
REQ-021 reg_ready SHALL be 1 only when the FSM is IDLE and not in reset.
REQ-022 rsp_valid SHALL pulse exactly one cycle after each accepted request (read or write); rsp_rdata SHALL be 0 for writes.
REQ-023 pad_in SHALL pass through a 2-flop synchronizer; DATA_IN SHALL return the second stage.
REQ-024 A rising edge on a synchronized bit (prev 0, now 1) SHALL set IRQ_STAT[i] on the next cycle when IRQ_EN[i]=1.
REQ-025 A same-cycle W1C and new edge on one bit SHALL leave the bit set.
REQ-026 irq SHALL be a registered |(IRQ_STAT & IRQ_EN), one cycle after status changes.
REQ-027 pad_out, pad_dm and pad_inp_dis SHALL be registered; pad_oe_n[i] SHALL be ~OUT_EN[i] OR force[i], registered.
REQ-028 pad_inp_dis[i] SHALL be 1 exactly when pad_dm pin i equals 3'b000.
REQ-029 A MODE write SHALL start the FSM: IDLE -> DRAIN -> APPLY -> RESTORE -> IDLE.
REQ-030 DRAIN: force[i]=1 for masked pins (pad_oe_n=1) for SETTLE cycles.
REQ-031 APPLY: one cycle; masked pins load dm; unmasked pins unchanged.
REQ-032 RESTORE: force held for SETTLE cycles, then cleared on return to IDLE.
REQ-033 MODE write with mask 0 SHALL complete the FSM sequence with no pad change.
REQ-034 Busy (MODE read bit0) SHALL be 1 in every non-IDLE state; total busy = 2*SETTLE+1 cycles.
REQ-035 Edge detection and irq SHALL operate during reconfiguration.

Reset
REQ-036 On rst: pad_out=0, pad_oe_n=all 1, pad_dm=3'b001 per pin, pad_inp_dis=0, irq=0, rsp_valid=0, rsp_rdata=0, all registers and synchronizers 0, force=0, FSM IDLE.
REQ-037 rst asserted mid-reconfiguration SHALL abort to reset values in the following cycle; no partial dm SHALL remain.
REQ-038 reg_ready SHALL be 0 during rst and 1 the cycle after deassertion.

Verification
REQ-039 Reset: after rst, pad_oe_n=8'hFF, pad_dm=24'o11111111, reg_ready=1.
REQ-040 Write OUT_EN=8'h0F, DATA_OUT=8'h05 -> pad_oe_n=8'hF0, pad_out=8'h05 one cycle after each accept; rsp_valid pulses.
REQ-041 MODE write dm=3'b110, mask=8'h03, SETTLE=4 -> pins0-1 oe_n=1 for 9 cycles; dm changes at cycle 5; reg_ready=0 for 9 cycles; busy read 1 then 0.
REQ-042 IRQ_EN=8'h01; drive pad_in[0] 0->1 -> IRQ_STAT=1 after 3 cycles, irq high one cycle later; W1C 1 -> irq low; simultaneous edge and W1C -> bit stays 1.
REQ-043 MODE dm=3'b000, mask=8'h80 -> pad_inp_dis[7]=1 after APPLY; rst in RESTORE -> all reset values next cycle.
